// File: rtl/demux_1to2_32bit_buf_pkg.sv
// Shared definitions for the buffered 1-to-2 demultiplexer: select encodings
// and default geometry.
package demux_1to2_32bit_buf_pkg;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH = 2;

endpackage

// File: rtl/demux_1to2_32bit_buf_fifo.sv
// Single-clock FIFO with one push and one pop port.
// The head word is registered storage, so a push is visible one cycle later.
module sync_fifo_1r1w #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/demux_1to2_32bit_buf.sv
// Buffered 1-to-2 demultiplexer: each accepted word is steered by in_sel into
// the FIFO of port A or port B.
module demux_1to2_32bit_buf
    import demux_1to2_32bit_buf_pkg::*;
#(
    parameter  int unsigned WIDTH = DEFAULT_WIDTH,
    parameter  int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [AW:0]      a_count,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [AW:0]      b_count
);

    logic a_full, a_empty, b_full, b_empty;
    logic push_a, push_b;

    // Readiness depends only on registered fullness; a same-cycle pop never frees a slot.
    assign in_ready = (in_sel == SEL_B) ? ~b_full : ~a_full;
    assign push_a   = in_valid && in_ready && (in_sel == SEL_A);
    assign push_b   = in_valid && in_ready && (in_sel == SEL_B);
    assign a_valid  = ~a_empty;
    assign b_valid  = ~b_empty;

    sync_fifo_1r1w #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .push      (push_a),
        .push_data (in_data),
        .pop       (a_ready),
        .full      (a_full),
        .empty     (a_empty),
        .count     (a_count),
        .head      (a_data)
    );

    sync_fifo_1r1w #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .push      (push_b),
        .push_data (in_data),
        .pop       (b_ready),
        .full      (b_full),
        .empty     (b_empty),
        .count     (b_count),
        .head      (b_data)
    );

endmodule

// File: tb/tb_demux_1to2_32bit_buf.sv
// Directed and random-soak checks for the buffered 1-to-2 demultiplexer.
module tb_demux_1to2_32bit_buf;

    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_data;
    logic        a_valid;
    logic        a_ready;
    logic [1:0]  a_count;
    logic [31:0] b_data;
    logic        b_valid;
    logic        b_ready;
    logic [1:0]  b_count;

    int checks = 0;
    int fails  = 0;

    demux_1to2_32bit_buf #(
        .WIDTH (32),
        .DEPTH (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_count  (a_count),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_count  (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 32'hDEAD0001;
        step();
        in_data  = 32'hDEAD0002;
        step();
        in_data  = 32'hDEAD0003;
        checks++;
        if (a_count !== 2'd2) begin fails++; $display("FAIL reset_prefill_count: got %0d expected 2", a_count); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (a_valid !== 1'b0) begin fails++; $display("FAIL reset_a_valid: got %b expected 0", a_valid); end
        checks++;
        if (a_count !== 2'd0) begin fails++; $display("FAIL reset_a_count: got %0d expected 0", a_count); end
        checks++;
        if (a_data !== 32'h0) begin fails++; $display("FAIL reset_a_data: got %h expected 00000000", a_data); end
        checks++;
        if (b_valid !== 1'b0 || b_data !== 32'h0) begin fails++; $display("FAIL reset_b: got valid %b data %h expected 0 00000000", b_valid, b_data); end
        in_valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready_a: got %b expected 1", in_ready); end
        in_sel = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready_b: got %b expected 1", in_ready); end
        step();
        checks++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0) begin fails++; $display("FAIL reset_no_push: got a_valid %b b_valid %b expected 0 0", a_valid, b_valid); end
    endtask

    task automatic test_steering();
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 32'h11111111;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL steer_ready: got %b expected 1", in_ready); end
        step();
        checks++;
        if (a_valid !== 1'b1 || a_data !== 32'h11111111) begin fails++; $display("FAIL steer_a: got valid %b data %h expected 1 11111111", a_valid, a_data); end
        checks++;
        if (b_valid !== 1'b0) begin fails++; $display("FAIL steer_a_not_b: got b_valid %b expected 0", b_valid); end
        in_sel  = 1'b1;
        in_data = 32'h22222222;
        step();
        checks++;
        if (b_valid !== 1'b1 || b_data !== 32'h22222222) begin fails++; $display("FAIL steer_b: got valid %b data %h expected 1 22222222", b_valid, b_data); end
        checks++;
        if (a_valid !== 1'b0) begin fails++; $display("FAIL steer_b_not_a: got a_valid %b expected 0", a_valid); end
        in_valid = 1'b0;
        step();
        checks++;
        if (b_valid !== 1'b0 || b_count !== 2'd0) begin fails++; $display("FAIL steer_drain: got b_valid %b b_count %0d expected 0 0", b_valid, b_count); end
    endtask

    task automatic test_backpressure();
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = 32'hB0000001;
        step();
        in_data  = 32'hB0000002;
        step();
        in_data  = 32'hB0000003;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_b_full: got %b expected 0", in_ready); end
        step();
        checks++;
        if (b_count !== 2'd2 || b_data !== 32'hB0000001) begin fails++; $display("FAIL bp_b_hold: got count %0d data %h expected 2 B0000001", b_count, b_data); end
        in_sel  = 1'b0;
        in_data = 32'hA5A5A5A5;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_a: got %b expected 1", in_ready); end
        step();
        checks++;
        if (a_valid !== 1'b1 || a_data !== 32'hA5A5A5A5 || a_count !== 2'd1) begin fails++; $display("FAIL bp_a_push: got valid %b data %h count %0d expected 1 A5A5A5A5 1", a_valid, a_data, a_count); end
        checks++;
        if (b_count !== 2'd2) begin fails++; $display("FAIL bp_b_untouched: got %0d expected 2", b_count); end
        in_valid = 1'b0;
        a_ready  = 1'b1;
        b_ready  = 1'b1;
        step();
        checks++;
        if (b_data !== 32'hB0000002 || b_count !== 2'd1 || a_count !== 2'd0) begin fails++; $display("FAIL bp_drain1: got b_data %h b_count %0d a_count %0d expected B0000002 1 0", b_data, b_count, a_count); end
        step();
        checks++;
        if (b_count !== 2'd0) begin fails++; $display("FAIL bp_drain2: got %0d expected 0", b_count); end
    endtask

    task automatic test_full_pop();
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 32'hA0000001;
        step();
        in_data  = 32'hA0000002;
        step();
        a_ready  = 1'b1;
        in_data  = 32'hA0000003;
        #1;
        checks++;
        if (a_count !== 2'd2 || in_ready !== 1'b0) begin fails++; $display("FAIL fullpop_refuse: got count %0d ready %b expected 2 0", a_count, in_ready); end
        step();
        checks++;
        if (a_count !== 2'd1 || a_data !== 32'hA0000002) begin fails++; $display("FAIL fullpop_after_pop: got count %0d data %h expected 1 A0000002", a_count, a_data); end
        #1;
        checks++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL fullpop_ready_again: got %b expected 1", in_ready); end
        step();
        checks++;
        if (a_count !== 2'd1 || a_data !== 32'hA0000003) begin fails++; $display("FAIL fullpop_accept: got count %0d data %h expected 1 A0000003", a_count, a_data); end
        in_valid = 1'b0;
        step();
        checks++;
        if (a_count !== 2'd0 || a_valid !== 1'b0) begin fails++; $display("FAIL fullpop_drain: got count %0d valid %b expected 0 0", a_count, a_valid); end
    endtask

    task automatic test_back_to_back();
        a_ready  = 1'b0;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 32'hA0;
        step();
        a_ready  = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            in_data = 32'hA0 + 32'(i);
            checks++;
            if (a_count !== 2'd1 || a_data !== 32'hA0 + 32'(i - 1)) begin fails++; $display("FAIL b2b_step%0d: got count %0d data %h expected 1 %h", i, a_count, a_data, 32'hA0 + 32'(i - 1)); end
            step();
        end
        checks++;
        if (a_count !== 2'd1 || a_data !== 32'hB4) begin fails++; $display("FAIL b2b_final: got count %0d data %h expected 1 000000b4", a_count, a_data); end
        in_valid = 1'b0;
        step();
        checks++;
        if (a_count !== 2'd0) begin fails++; $display("FAIL b2b_drain: got %0d expected 0", a_count); end
    endtask

    task automatic test_soak();
        logic [31:0] qa[$];
        logic [31:0] qb[$];
        logic        exp_ready;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_sel   = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            a_ready  = ($urandom_range(0, 2) == 0);
            b_ready  = ($urandom_range(0, 2) != 0);
            #1;
            exp_ready = in_sel ? (qb.size() < 2) : (qa.size() < 2);
            checks++;
            if (in_ready !== exp_ready) begin fails++; $display("FAIL soak_ready c%0d: got %b expected %b", cyc, in_ready, exp_ready); end
            checks++;
            if (a_count !== 2'(qa.size()) || a_valid !== (qa.size() != 0) || (qa.size() != 0 && a_data !== qa[0])) begin
                fails++;
                $display("FAIL soak_a c%0d: got count %0d data %h expected %0d %h", cyc, a_count, a_data, qa.size(), (qa.size() != 0) ? qa[0] : 32'h0);
            end
            checks++;
            if (b_count !== 2'(qb.size()) || b_valid !== (qb.size() != 0) || (qb.size() != 0 && b_data !== qb[0])) begin
                fails++;
                $display("FAIL soak_b c%0d: got count %0d data %h expected %0d %h", cyc, b_count, b_data, qb.size(), (qb.size() != 0) ? qb[0] : 32'h0);
            end
            if (a_ready && qa.size() != 0) void'(qa.pop_front());
            if (b_ready && qb.size() != 0) void'(qb.pop_front());
            if (in_valid && exp_ready) begin
                if (in_sel) qb.push_back(in_data);
                else        qa.push_back(in_data);
            end
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_data  = '0;
        in_sel   = 1'b0;
        in_valid = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        step();
        test_reset();
        test_steering();
        test_backpressure();
        test_full_pop();
        test_back_to_back();
        test_soak();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
